// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB machine timer: register map, CTRL field layout,
// compare reset value and the wait-state ceiling.
package apb_timer_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_MTIME_LO = 8'h04;
    localparam logic [7:0] OFF_MTIME_HI = 8'h08;
    localparam logic [7:0] OFF_CMP_LO   = 8'h0C;
    localparam logic [7:0] OFF_CMP_HI   = 8'h10;
    localparam logic [7:0] OFF_STATUS   = 8'h14;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_IE_BIT    = 1;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int unsigned WAIT_STATES_MAX = 7;

    typedef struct packed {
        logic [7:0] presc;
        logic       ie;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]                     = c.en;
        w[CTRL_IE_BIT]                     = c.ie;
        w[CTRL_PRESC_MSB:CTRL_PRESC_LSB]   = c.presc;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle between the CPU-side master and the timer completer.
interface apb_timer_if;
    import apb_timer_pkg::*;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    // Handshake: a transfer is in ACCESS while psel & penable; it completes on the
    // rising edge where pready is also high, and only then do writes or read side
    // effects take place. prdata is meaningful only in that completing read cycle.
    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );

endinterface

// File: rtl/apb_timer_counter.sv
// Prescaled 64-bit free-running MTIME with per-half software load and an
// unsigned MTIME >= CMP comparator.
module timer_counter
    import apb_timer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [7:0]  presc_i,
    input  logic        pcnt_clr_i,
    input  logic        ld_lo_i,
    input  logic        ld_hi_i,
    input  logic [31:0] ld_data_i,
    input  logic [63:0] cmp_i,
    output logic [63:0] mtime_o,
    output logic        hit_o
);

    logic [7:0]  pcnt_q, pcnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    always_comb begin
        tick    = en_i && (pcnt_q == presc_i);
        pcnt_d  = pcnt_q;
        if (pcnt_clr_i) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        end
        // A software load of either half wins over the tick for the whole cycle.
        mtime_d = mtime_q;
        if (ld_lo_i || ld_hi_i) begin
            if (ld_lo_i) mtime_d[31:0]  = ld_data_i;
            if (ld_hi_i) mtime_d[63:32] = ld_data_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_q  <= '0;
            mtime_q <= '0;
        end else begin
            pcnt_q  <= pcnt_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;
    assign hit_o   = (mtime_q >= cmp_i);

endmodule

// File: rtl/apb_timer.sv
// APB completer for the machine timer: bus handshake with wait states, register
// file, atomic MTIME_HI shadow and the sticky compare interrupt.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        pclk,
    input  logic        preset_n,
    apb_timer_if.slave  bus,
    output logic        timer_irq
);

    localparam int unsigned WS_CLAMP = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [2:0]  WS       = 3'(WS_CLAMP);

    logic [2:0]  wait_cnt_q, wait_cnt_d;
    ctrl_t       ctrl_q;
    logic [63:0] cmp_q;
    logic        pend_q, pend_d;
    logic        irq_q;
    logic [31:0] shadow_q;
    logic [63:0] mtime;
    logic        hit;

    logic        access, commit, wr_en, rd_en;
    logic [7:0]  addr;
    logic [31:0] rdata_mux;
    logic        unused_paddr;

    assign access = bus.psel & bus.penable;
    assign addr   = bus.paddr[7:0];
    assign unused_paddr = ^bus.paddr[31:8];

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!access) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WS) begin
            wait_cnt_d = wait_cnt_q + 3'd1;
        end
    end

    // Gating with preset_n keeps pready low for a transfer caught by reset.
    assign bus.pready = access & (wait_cnt_q == WS) & preset_n;
    assign commit     = bus.pready;
    assign wr_en      = commit & bus.pwrite;
    assign rd_en      = commit & ~bus.pwrite;

    timer_counter u_counter (
        .clk_i      (pclk),
        .rst_ni     (preset_n),
        .en_i       (ctrl_q.en),
        .presc_i    (ctrl_q.presc),
        .pcnt_clr_i (wr_en && (addr == OFF_CTRL)),
        .ld_lo_i    (wr_en && (addr == OFF_MTIME_LO)),
        .ld_hi_i    (wr_en && (addr == OFF_MTIME_HI)),
        .ld_data_i  (bus.pwdata),
        .cmp_i      (cmp_q),
        .mtime_o    (mtime),
        .hit_o      (hit)
    );

    // Set beats a simultaneous write-1-to-clear.
    always_comb begin
        pend_d = pend_q;
        if (hit) begin
            pend_d = 1'b1;
        end else if (wr_en && (addr == OFF_STATUS) && bus.pwdata[0]) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_cnt_q <= '0;
            ctrl_q     <= '0;
            cmp_q      <= CMP_RESET;
            pend_q     <= 1'b0;
            irq_q      <= 1'b0;
            shadow_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
            irq_q      <= pend_q & ctrl_q.ie;
            if (wr_en && (addr == OFF_CTRL)) begin
                ctrl_q.en    <= bus.pwdata[CTRL_EN_BIT];
                ctrl_q.ie    <= bus.pwdata[CTRL_IE_BIT];
                ctrl_q.presc <= bus.pwdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
            end
            if (wr_en && (addr == OFF_CMP_LO)) cmp_q[31:0]  <= bus.pwdata;
            if (wr_en && (addr == OFF_CMP_HI)) cmp_q[63:32] <= bus.pwdata;
            if (rd_en && (addr == OFF_MTIME_LO)) shadow_q <= mtime[63:32];
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (addr)
            OFF_CTRL:     rdata_mux = ctrl_to_word(ctrl_q);
            OFF_MTIME_LO: rdata_mux = mtime[31:0];
            OFF_MTIME_HI: rdata_mux = shadow_q;
            OFF_CMP_LO:   rdata_mux = cmp_q[31:0];
            OFF_CMP_HI:   rdata_mux = cmp_q[63:32];
            OFF_STATUS:   rdata_mux = {31'd0, pend_q};
            default:      rdata_mux = '0;
        endcase
    end

    assign bus.prdata = rd_en ? rdata_mux : 32'd0;
    assign timer_irq  = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer with WAIT_STATES = 2: directed tables, corner
// sequences and a randomized run against a spec-level reference model.
module tb_apb_timer;
  import apb_timer_pkg::*;

  localparam int WS = 2;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  logic timer_irq;

  apb_timer_if bus ();

  apb_timer #(.WAIT_STATES(WS)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // reference model state
  logic [63:0] m_mtime, m_cmp;
  logic [7:0]  m_pcnt, m_presc;
  logic        m_en, m_ie, m_pend, m_irq;
  logic [31:0] m_shadow;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mtime = '0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_pcnt = '0; m_presc = '0; m_en = 0; m_ie = 0;
    m_pend = 0; m_irq = 0; m_shadow = '0;
  endfunction

  // One clock edge of the timer as described by its register rules.
  function automatic void model_edge(input logic cw, input logic cr, input logic [7:0] a, input logic [31:0] d);
    logic tick, hit;
    tick = m_en && (m_pcnt == m_presc);
    hit  = (m_mtime >= m_cmp);
    m_irq = m_pend & m_ie;
    if (hit) m_pend = 1'b1;
    else if (cw && a == OFF_STATUS && d[0]) m_pend = 1'b0;
    if (cr && a == OFF_MTIME_LO) m_shadow = m_mtime[63:32];
    if (cw && a == OFF_MTIME_LO) m_mtime = {m_mtime[63:32], d};
    else if (cw && a == OFF_MTIME_HI) m_mtime = {d, m_mtime[31:0]};
    else if (tick) m_mtime = m_mtime + 64'd1;
    if (cw && a == OFF_CTRL) m_pcnt = 8'd0;
    else if (m_en) m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
    if (cw && a == OFF_CTRL) begin
      m_en = d[0]; m_ie = d[1]; m_presc = d[15:8];
    end
    if (cw && a == OFF_CMP_LO) m_cmp[31:0] = d;
    if (cw && a == OFF_CMP_HI) m_cmp[63:32] = d;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      OFF_CTRL:     return {16'd0, m_presc, 6'd0, m_ie, m_en};
      OFF_MTIME_LO: return m_mtime[31:0];
      OFF_MTIME_HI: return m_shadow;
      OFF_CMP_LO:   return m_cmp[31:0];
      OFF_CMP_HI:   return m_cmp[63:32];
      OFF_STATUS:   return {31'd0, m_pend};
      default:      return 32'd0;
    endcase
  endfunction

  // driver tasks
  task automatic step(input logic cw, input logic cr, input logic [7:0] a, input logic [31:0] d);
    @(posedge pclk);
    model_edge(cw, cr, a, d);
    #1;
    check("irq", timer_irq, m_irq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    logic last;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = {24'h0, a}; bus.pwdata = d;
    #1;
    check("setup_pready", bus.pready, 0);
    step(1'b0, 1'b0, a, d);
    bus.penable = 1'b1;
    for (int i = 0; i <= WS; i++) begin
      last = (i == WS);
      #1;
      check("wr_pready", bus.pready, last);
      step(last, 1'b0, a, d);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] data);
    logic last;
    data = '0;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = {24'h0, a}; bus.pwdata = $urandom;
    #1;
    check("setup_prdata", bus.prdata, 0);
    step(1'b0, 1'b0, a, 32'h0);
    bus.penable = 1'b1;
    for (int i = 0; i <= WS; i++) begin
      last = (i == WS);
      #1;
      check("rd_pready", bus.pready, last);
      if (last) begin
        exp_q.push_back(model_read(a));
        data = bus.prdata;
        check("rdata", data, exp_q.pop_front());
      end else begin
        check("wait_prdata", bus.prdata, 0);
      end
      step(1'b0, last, a, 32'h0);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic apply_reset();
    preset_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    repeat (2) @(posedge pclk);
    #1;
    preset_n = 1'b1;
    model_reset();
  endtask

  logic [31:0] rd, rd2;
  logic [7:0]  addr_list[7];

  initial begin
    addr_list[0] = OFF_CTRL;   addr_list[1] = OFF_MTIME_LO; addr_list[2] = OFF_MTIME_HI;
    addr_list[3] = OFF_CMP_LO; addr_list[4] = OFF_CMP_HI;   addr_list[5] = OFF_STATUS;
    addr_list[6] = 8'h1C;

    vt[0] = '{OFF_CMP_LO,   32'h1234_5678, 32'h1234_5678};
    vt[1] = '{OFF_CMP_HI,   32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[2] = '{OFF_MTIME_LO, 32'h0000_0123, 32'h0000_0123};
    vt[3] = '{OFF_STATUS,   32'h0000_0001, 32'h0000_0000};
    vt[4] = '{8'h18,        32'hFFFF_FFFF, 32'h0000_0000};
    vt[5] = '{8'hFC,        32'hA5A5_A5A5, 32'h0000_0000};
    vt[6] = '{OFF_CTRL,     32'hFFFF_FFFE, 32'h0000_FF02};

    // reset state, with an access held open during reset
    preset_n = 1'b0;
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    #12;
    check("rst_pready", bus.pready, 0);
    check("rst_prdata", bus.prdata, 0);
    check("rst_irq", timer_irq, 0);
    apply_reset();
    apb_read(OFF_CMP_LO, rd);  check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    apb_read(OFF_CMP_HI, rd);  check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
    apb_read(OFF_CTRL, rd);    check("rst_ctrl", rd, 32'h0);

    // register table: write then read back
    for (int i = 0; i < 7; i++) begin
      apb_write(vt[i].addr, vt[i].wdata);
      apb_read(vt[i].addr, rd);
      check("table", rd, vt[i].exp);
    end

    // prescaled count: PRESC = 3, 40 idle cycles
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_MTIME_LO, 32'h0);
    apb_write(OFF_MTIME_HI, 32'h0);
    apb_write(OFF_CTRL, 32'h0000_0301);
    idle(40);
    apb_read(OFF_MTIME_LO, rd);
    check("presc_count", rd, 32'h0000_000A);

    // atomic read across the LO->HI carry
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_MTIME_LO, 32'h0);
    apb_write(OFF_MTIME_HI, 32'h0);
    apb_write(OFF_CTRL, 32'h1);
    apb_write(OFF_MTIME_LO, 32'hFFFF_FFFC);
    apb_read(OFF_MTIME_LO, rd);
    apb_read(OFF_MTIME_HI, rd2);
    check("atomic_lo", rd, 32'hFFFF_FFFF);
    check("atomic_hi", rd2, 32'h0);
    apb_read(OFF_MTIME_LO, rd);
    apb_read(OFF_MTIME_HI, rd2);
    check("atomic_hi_next", rd2, 32'h1);

    // 64-bit wrap and write-over-tick priority
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_MTIME_LO, 32'hFFFF_FFFF);
    apb_write(OFF_MTIME_HI, 32'hFFFF_FFFF);
    apb_write(OFF_CTRL, 32'h1);
    apb_read(OFF_MTIME_LO, rd);
    apb_read(OFF_MTIME_HI, rd2);
    check("wrap_lo", rd, 32'h2);
    check("wrap_hi", rd2, 32'h0);
    apb_write(OFF_MTIME_LO, 32'h0000_1000);
    apb_read(OFF_MTIME_LO, rd);
    check("write_priority", rd, 32'h0000_1003);

    // aborted write: psel drops after the first ACCESS cycle
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = {24'h0, OFF_CTRL}; bus.pwdata = 32'h0000_0302;
    #1;
    step(1'b0, 1'b0, OFF_CTRL, 32'h0);
    bus.penable = 1'b1;
    #1;
    check("abort_pready", bus.pready, 0);
    step(1'b0, 1'b0, OFF_CTRL, 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1;
    check("abort_idle_pready", bus.pready, 0);
    idle(2);
    apb_read(OFF_CTRL, rd);
    check("abort_ctrl", rd, 32'h1);

    // compare and interrupt timing
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_MTIME_LO, 32'h0);
    apb_write(OFF_MTIME_HI, 32'h0);
    apb_write(OFF_CMP_LO, 32'h5);
    apb_write(OFF_CMP_HI, 32'h0);
    apb_write(OFF_STATUS, 32'h1);
    apb_write(OFF_CTRL, 32'h3);
    for (int k = 0; k < 20 && m_mtime != 64'd5; k++) idle(1);
    idle(1);
    check("irq_lag1", timer_irq, 0);
    idle(1);
    check("irq_lag2", timer_irq, 1);
    apb_write(OFF_STATUS, 32'h1);
    apb_read(OFF_STATUS, rd);
    check("pend_sticky", rd, 32'h1);

    // reset asserted in the middle of an ACCESS phase
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = {24'h0, OFF_CMP_LO}; bus.pwdata = 32'h0000_0042;
    #1;
    step(1'b0, 1'b0, OFF_CMP_LO, 32'h0);
    bus.penable = 1'b1;
    step(1'b0, 1'b0, OFF_CMP_LO, 32'h0);
    #3;
    preset_n = 1'b0;
    #1;
    check("midrst_pready", bus.pready, 0);
    check("midrst_prdata", bus.prdata, 0);
    check("midrst_irq", timer_irq, 0);
    apply_reset();
    apb_read(OFF_CMP_LO, rd);
    check("midrst_cmp_lo", rd, 32'hFFFF_FFFF);

    // interrupt falls after moving CMP above MTIME and clearing PEND
    apb_write(OFF_CMP_LO, 32'h5);
    apb_write(OFF_CMP_HI, 32'h0);
    apb_write(OFF_CTRL, 32'h3);
    idle(10);
    check("irq_high", timer_irq, 1);
    apb_write(OFF_CMP_HI, 32'h1);
    apb_write(OFF_STATUS, 32'h1);
    idle(2);
    check("irq_fall", timer_irq, 0);
    apb_read(OFF_STATUS, rd);
    check("pend_cleared", rd, 32'h0);

    // randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      int op;
      logic [7:0]  a;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      a  = addr_list[$urandom_range(0, 6)];
      case (a)
        OFF_CTRL:     d = {16'd0, 8'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3))};
        OFF_MTIME_LO: d = $urandom_range(0, 60);
        OFF_CMP_LO:   d = $urandom_range(0, 60);
        OFF_MTIME_HI: d = $urandom_range(0, 1);
        OFF_CMP_HI:   d = $urandom_range(0, 1);
        default:      d = $urandom;
      endcase
      if (op <= 4) apb_write(a, d);
      else if (op <= 8) apb_read(a, rd);
      else idle($urandom_range(1, 4));
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_timer.md
# apb_timer

- APB completer for the timer peripheral: a 64-bit free-running machine timer with prescaler, 64-bit compare and a sticky interrupt.
- Sits directly downstream of the CPU's APB master on the timer select, in peripheral region 0x000–0x0FF, and returns read data and `pready` to it.
- Drives a level interrupt request toward the platform interrupt controller.

## Interface
Parameters:
- WAIT_STATES, 0, extra ACCESS cycles before `pready` asserts (0–7)

Ports:
- pclk  in  1  APB/system clock; all logic on rising edge
- preset_n  in  1  reset, asynchronous, active-low
- psel  in  1  timer select from APB master
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  32  byte address; only [7:0] decoded, word-aligned
- pwdata  in  32  write data
- prdata  out  32  read data, valid while `pready` = 1 in a read ACCESS
- pready  out  1  transfer completes on this cycle's rising edge
- timer_irq  out  1  registered interrupt request, level-high

## Operation
Register map (offset, reset value):
- 0x00 CTRL (0): [0] EN, [1] IE, [15:8] PRESC; other bits read 0
- 0x04 MTIME_LO, 0x08 MTIME_HI (0)
- 0x0C CMP_LO, 0x10 CMP_HI (0xFFFF_FFFF each)
- 0x14 STATUS (0): [0] PEND, write-1-to-clear
- Any other offset reads 0; writes to it are ignored.

Counting:
- The prescaler counter `pcnt` (8 bit) runs while EN = 1.
- When `pcnt == PRESC`, `pcnt` goes to 0 and MTIME increments by 1. Otherwise `pcnt` increments.
- A tick therefore occurs every PRESC+1 cycles.
- EN = 0 holds `pcnt` and MTIME.
- MTIME wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- Any CTRL write clears `pcnt`.

Register writes and priority:
- A software write to MTIME_LO or MTIME_HI replaces only that half and suppresses the increment in that cycle.
- Write has priority over tick.

Compare and interrupt:
- PEND is set on any cycle where MTIME ≥ CMP, as a 64-bit unsigned compare, regardless of EN.
- A W1C write and the set condition in the same cycle: set wins.
- `timer_irq` is registered from PEND & IE.

Atomic 64-bit read:
- A completed read of MTIME_LO latches MTIME[63:32] into a shadow register.
- A read of MTIME_HI returns the shadow, not the live value.

APB handshake, ACCESS = `psel` & `penable`:
- A wait counter clears whenever ACCESS is low.
- The counter increments each ACCESS cycle while it is below WAIT_STATES.
- `pready` = ACCESS & (wait count == WAIT_STATES).
- Register writes and read side effects (shadow latch, W1C) happen only at the edge where ACCESS & `pready`.
- `prdata` is combinationally muxed from `paddr[7:0]` when ACCESS & `pready` & !`pwrite`, and is 0 otherwise.
- The SETUP cycle (`psel` = 1, `penable` = 0) has no effect.

## Timing
- Reset (`preset_n` low, asynchronous, any time including mid-transfer):
  - `prdata` = 0, `pready` = 0, `timer_irq` = 0
  - all registers at their reset values
  - shadow, `pcnt` and wait counter = 0
  - any in-flight transfer is discarded with no side effects
- Read latency: data is available in the first ACCESS cycle when WAIT_STATES = 0; otherwise WAIT_STATES ACCESS cycles later.
- Write visibility: a register written at edge N reads back the new value in any transfer whose ACCESS starts at N+1.
- Compare → PEND: PEND is set at the edge after MTIME ≥ CMP holds.
- PEND → `timer_irq`: one further cycle, with IE = 1.
- Back-to-back transfers (SETUP directly after a completed ACCESS) are supported with no idle cycle.
- If `psel` drops mid-wait, the wait counter clears and nothing commits.

## Structure
- Shared package `apb_timer_pkg` holds:
  - register offset localparams
  - CTRL bit positions
  - CMP reset constant
  - the WAIT_STATES limit
- Natural sub-module: `timer_counter`, containing prescaler, 64-bit MTIME with per-half load, and the ≥ compare (outputs MTIME and a `hit` flag).
- APB decode, handshake, CTRL/CMP/STATUS registers, shadow register and interrupt logic stay in `apb_timer`.

## Test plan
- **Reset:** assert `preset_n` mid-ACCESS → all outputs 0; read CMP_LO returns 0xFFFF_FFFF.
- **Prescaled count:** write CTRL = 0x0000_0301 (EN, PRESC = 3) → MTIME_LO reads 0x0A after 40 cycles, ±1 tick for read timing.
- **Compare/interrupt:** MTIME = 0, CMP = 5, CTRL = 0x3 → `timer_irq` rises 2 cycles after MTIME reaches 5. Then W1C STATUS = 1 while MTIME ≥ CMP → PEND stays 1. Then set CMP_HI = 1 and W1C → `timer_irq` falls.
- **Atomic read:** MTIME = 0x0000_0000_FFFF_FFFF, PRESC = 0, EN = 1; read LO then HI → HI returns 0, not 1.
- **Wait states:** WAIT_STATES = 2 → `pready` high exactly on the 3rd ACCESS cycle. A write is not committed if `psel` drops after the 1st ACCESS cycle.
- **Wrap and priority:** MTIME = all-ones, EN = 1, PRESC = 0 → wraps to 0. A write to MTIME_LO on a tick cycle stores the written value with no +1.
